// File: rtl/reg_writeback_queue.sv
// In-order writeback queue driving the register bank write port (rd/regWrite/writeData).
// Optional macro WB_BYPASS_EN: a non-load arriving at an empty, idle queue skips storage.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     in_is_load,
    input  logic                     load_resp_valid,
    input  logic [XLEN-1:0]          load_resp_data,
    output logic [4:0]               rd,
    output logic                     regWrite,
    output logic [XLEN-1:0]          writeData,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       rd_mem   [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [DEPTH-1:0] load_mem;
    logic [DEPTH-1:0] rdy_mem;

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             resp_err_q, resp_err_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             wen_n_q, wen_n_d;

    logic             full;
    logic             in_fire;
    logic             bypass;
    logic             enq_store;
    logic             retire;
    logic             fill_found;
    logic [AW-1:0]    fill_idx;
    logic [AW-1:0]    scan_idx;
    logic [DEPTH-1:0] entry_valid;
    logic [31:0]      entry_mask [DEPTH];
    logic [31:0]      busy_all;

    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign in_fire   = in_valid && !full;
    // Head readiness is the registered flag, so a fill landing on the head retires one edge later.
    assign retire    = (count_q != '0) && rdy_mem[head_q];

`ifdef WB_BYPASS_EN
    assign bypass    = in_fire && !in_is_load && (count_q == '0);
`else
    assign bypass    = 1'b0;
`endif
    assign enq_store = in_fire && !bypass;

    // Oldest waiting load: scan from the head, youngest first so the oldest match wins.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        scan_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            scan_idx = head_q + AW'(k);
            if ((CW'(k) < count_q) && load_mem[scan_idx] && !rdy_mem[scan_idx]) begin
                fill_found = 1'b1;
                fill_idx   = scan_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] offset;
            assign offset          = AW'(gi) - head_q;
            assign entry_valid[gi] = ({1'b0, offset} < count_q);
            assign entry_mask[gi]  = entry_valid[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        busy_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_all = busy_all | entry_mask[i];
        end
    end
    assign busy_mask = {busy_all[31:1], 1'b0};

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        resp_err_d = resp_err_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        wen_n_d    = 1'b1;
        if (load_resp_valid && !fill_found) begin
            resp_err_d = 1'b1;
        end
        if (enq_store) begin
            tail_d = tail_q + 1'b1;
        end
        // x0 writes are swallowed: address goes to 0, data holds, enable stays high.
        if (retire) begin
            head_d = head_q + 1'b1;
            if (rd_mem[head_q] != 5'd0) begin
                rd_d    = rd_mem[head_q];
                wdata_d = data_mem[head_q];
                wen_n_d = 1'b0;
            end else begin
                rd_d = 5'd0;
            end
        end else if (bypass) begin
            if (in_rd != 5'd0) begin
                rd_d    = in_rd;
                wdata_d = in_data;
                wen_n_d = 1'b0;
            end else begin
                rd_d = 5'd0;
            end
        end
        count_d = count_q + CW'(enq_store) - CW'(retire);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            wen_n_q    <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            resp_err_q <= resp_err_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            wen_n_q    <= wen_n_d;
        end
    end

    // Entry payload needs no reset: it is only observed while inside the occupied window.
    always_ff @(posedge clock) begin
        if (enq_store) begin
            rd_mem[tail_q]   <= in_rd;
            data_mem[tail_q] <= in_data;
            load_mem[tail_q] <= in_is_load;
            rdy_mem[tail_q]  <= !in_is_load;
        end
        if (load_resp_valid && fill_found) begin
            data_mem[fill_idx] <= load_resp_data;
            rdy_mem[fill_idx]  <= 1'b1;
        end
    end

    assign rd        = rd_q;
    assign regWrite  = wen_n_q;
    assign writeData = wdata_q;
    assign count     = count_q;
    assign resp_err  = resp_err_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic against a queue model.
// Honors WB_BYPASS_EN in the model when the macro is defined.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_rd;
    logic [XLEN-1:0]        in_data;
    logic                   in_is_load;
    logic                   load_resp_valid;
    logic [XLEN-1:0]        load_resp_data;
    logic [4:0]             rd;
    logic                   regWrite;
    logic [XLEN-1:0]        writeData;
    logic [31:0]            busy_mask;
    logic [$clog2(DEPTH):0] count;
    logic                   resp_err;

    reg_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .in_is_load(in_is_load), .load_resp_valid(load_resp_valid), .load_resp_data(load_resp_data),
        .rd(rd), .regWrite(regWrite), .writeData(writeData), .busy_mask(busy_mask),
        .count(count), .resp_err(resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_load;
        logic        ready;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        m_we;
    logic        m_err;
    logic [36:0] wlog[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] log_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    function automatic bit load_pending();
        foreach (mq[i]) if (mq[i].is_load && !mq[i].ready) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rd  = '0;
        m_wd  = '0;
        m_we  = 1'b1;
        m_err = 1'b0;
    endtask

    // One rising edge of the queue, applied to the pre-edge contents.
    task automatic model_edge();
        int   n;
        int   fi;
        bit   ret;
        bit   fire;
        ent_t e;
        n    = mq.size();
        ret  = (n > 0) && mq[0].ready;
        fire = in_valid && (n < DEPTH);
        fi   = -1;
        for (int i = 0; i < n; i++) if (fi < 0 && mq[i].is_load && !mq[i].ready) fi = i;
        if (load_resp_valid) begin
            if (fi >= 0) begin
                e = mq[fi];
                e.data = load_resp_data;
                e.ready = 1'b1;
                mq[fi] = e;
            end else begin
                m_err = 1'b1;
            end
        end
        m_we = 1'b1;
        if (ret) begin
            e = mq.pop_front();
            if (e.rd != 5'd0) begin
                m_rd = e.rd; m_wd = e.data; m_we = 1'b0;
            end else begin
                m_rd = 5'd0;
            end
        end
        if (BYP && fire && !in_is_load && n == 0) begin
            fire = 1'b0;
            if (in_rd != 5'd0) begin
                m_rd = in_rd; m_wd = in_data; m_we = 1'b0;
            end else begin
                m_rd = 5'd0;
            end
        end
        if (fire) begin
            e.rd = in_rd; e.data = in_data; e.is_load = in_is_load; e.ready = !in_is_load;
            mq.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] b;
        b = '0;
        foreach (mq[i]) if (mq[i].rd != 5'd0) b[mq[i].rd] = 1'b1;
        chk({tag, "_count"}, count, mq.size());
        chk({tag, "_in_ready"}, in_ready, mq.size() < DEPTH);
        chk({tag, "_busy"}, busy_mask, b);
        chk({tag, "_regWrite"}, regWrite, m_we);
        chk({tag, "_rd"}, rd, m_rd);
        chk({tag, "_wdata"}, writeData, m_wd);
        chk({tag, "_resp_err"}, resp_err, m_err);
    endtask

    task automatic cycle(input string tag, input bit v, input logic [4:0] r, input logic [31:0] d,
                         input bit ld, input bit lv, input logic [31:0] ldat);
        in_valid = v; in_rd = r; in_data = d; in_is_load = ld;
        load_resp_valid = lv; load_resp_data = ldat;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
        if (regWrite === 1'b0) wlog.push_back({rd, writeData});
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_data = '0; in_is_load = 1'b0;
        load_resp_valid = 1'b0; load_resp_data = '0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("rst_count", count, 0);
        chk("rst_regWrite", regWrite, 1);
        chk("rst_rd", rd, 0);
        chk("rst_wdata", writeData, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_err", resp_err, 0);
        reset = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Back-to-back non-loads
        wlog.delete();
        cycle("b2b", 1, 5'd5, 32'h11, 0, 0, 0);
        cycle("b2b", 1, 5'd6, 32'h22, 0, 0, 0);
        cycle("b2b", 1, 5'd7, 32'h33, 0, 0, 0);
        idle("b2b", 3);
        chk("b2b_n", wlog.size(), 3);
        chk("b2b_w0", log_at(0), {5'd5, 32'h11});
        chk("b2b_w1", log_at(1), {5'd6, 32'h22});
        chk("b2b_w2", log_at(2), {5'd7, 32'h33});

        // Load followed by younger non-load
        wlog.delete();
        cycle("ld", 1, 5'd10, 32'h0, 1, 0, 0);
        cycle("ld", 1, 5'd11, 32'hAA, 0, 0, 0);
        idle("ld", 3);
        chk("ld_busy11", busy_mask[11], 1);
        cycle("ld", 0, 5'd0, 32'h0, 0, 1, 32'hDEADBEEF);
        idle("ld", 3);
        chk("ld_n", wlog.size(), 2);
        chk("ld_w0", log_at(0), {5'd10, 32'hDEADBEEF});
        chk("ld_w1", log_at(1), {5'd11, 32'hAA});

        // Fill to DEPTH behind a stalled load
        wlog.delete();
        cycle("full", 1, 5'd1, 32'h0, 1, 0, 0);
        cycle("full", 1, 5'd2, 32'h102, 0, 0, 0);
        cycle("full", 1, 5'd3, 32'h103, 0, 0, 0);
        cycle("full", 1, 5'd4, 32'h104, 0, 0, 0);
        chk("full_count", count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        cycle("full", 1, 5'd9, 32'h109, 0, 0, 0);
        chk("full_hold", count, DEPTH);
        cycle("full", 0, 5'd0, 32'h0, 0, 1, 32'h0BAD);
        idle("full", 6);
        chk("full_n", wlog.size(), 4);
        chk("full_w0", log_at(0), {5'd1, 32'h0BAD});
        chk("full_w1", log_at(1), {5'd2, 32'h102});
        chk("full_w2", log_at(2), {5'd3, 32'h103});
        chk("full_w3", log_at(3), {5'd4, 32'h104});

        // Write to x0 is dropped
        wlog.delete();
        cycle("x0", 1, 5'd0, 32'h55, 0, 0, 0);
        idle("x0", 2);
        chk("x0_n", wlog.size(), 0);
        chk("x0_busy", busy_mask, 0);

        // Single non-load latency into an empty queue
        cycle("lat", 1, 5'd3, 32'h7, 0, 0, 0);
        chk("lat_e0", regWrite, BYP ? 1'b0 : 1'b1);
        idle("lat", 1);
        chk("lat_e1", regWrite, BYP ? 1'b1 : 1'b0);
        chk("lat_rd", rd, 3);
        idle("lat", 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bit v, ld, lv;
            logic [4:0] r;
            v  = ($urandom_range(0, 9) < 7);
            ld = ($urandom_range(0, 9) < 4);
            r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lv = load_pending() && ($urandom_range(0, 1) == 1);
            cycle("rnd", v, r, $urandom, ld, lv, $urandom);
        end
        for (int n = 0; n < 20; n++) begin
            cycle("drain", 1'b0, 5'd0, 32'd0, 1'b0, load_pending(), $urandom);
        end
        chk("drain_count", count, 0);

        // Asynchronous reset mid-operation, then an orphan load response
        cycle("mid", 1, 5'd9, 32'h0, 1, 0, 0);
        cycle("mid", 1, 5'd12, 32'h1, 0, 0, 0);
        cycle("mid", 1, 5'd13, 32'h2, 0, 0, 0);
        chk("mid_count3", count, 3);
        in_valid = 1'b0; load_resp_valid = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("mid_count", count, 0);
        chk("mid_regWrite", regWrite, 1);
        chk("mid_busy", busy_mask, 0);
        chk("mid_rd", rd, 0);
        chk("mid_wdata", writeData, 0);
        @(negedge clock);
        chk("mid_hold", count, 0);
        reset = 1'b1;
        cycle("orphan", 0, 5'd0, 32'h0, 0, 1, 32'h1234);
        chk("orphan_err", resp_err, 1);
        idle("orphan", 2);
        chk("orphan_sticky", resp_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

In-order writeback queue that is the writer side of the register bank's write port (`rd`, `regWrite`, `writeData`). It accepts completed results from the memory stage, holds loads until the data cache returns their data, and retires entries to the bank one per cycle in program order. It also exports a per-register pending-write mask to the hazard unit.

## Interface
- `DEPTH`, 4: queue entries, power of two, 2..16.
- `XLEN`, 32: data width.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `in_valid`  in  1  result offered by the memory stage.
- `in_ready`  out  1  `!full`; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_rd`  in  5  destination register.
- `in_data`  in  XLEN  result data; ignored when `in_is_load`=1.
- `in_is_load`  in  1  data arrives later on `load_resp_*`.
- `load_resp_valid`  in  1  cache load data valid; one-cycle pulse per load, in program order.
- `load_resp_data`  in  XLEN  load data.
- `rd`  out  5  bank write address.
- `regWrite`  out  1  bank write enable, active-low: 0 writes.
- `writeData`  out  XLEN  bank write data.
- `busy_mask`  out  32  bit i=1 if any valid entry targets xi; bit 0 is always 0.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `resp_err`  out  1  sticky: a load response arrived with no load awaiting data.

## Operation
- Each entry holds {rd, data, is_load, ready}. A non-load enqueues with ready=1. A load enqueues with ready=0.
- A fill pointer tracks the oldest load entry with ready=0. `load_resp_valid` writes `load_resp_data` into that entry, sets ready=1, and advances the pointer.
- If `load_resp_valid` arrives with no such entry, the response is dropped and `resp_err` is set. `resp_err` clears only on reset.
- Retire: when the head entry has ready=1, it dequeues at the edge and registers `rd`/`writeData`. `regWrite` is driven 0 for exactly one cycle.
- An entry with rd=0 dequeues normally but keeps `regWrite`=1, with `rd`=0 and `writeData` unchanged.
- When no entry retires, `regWrite`=1 and `rd`/`writeData` hold their last values.
- Enqueue, fill and retire may all occur at the same edge. The count updates by +1, −1 or 0 accordingly.
- A load response may target the head entry at the same edge the head is evaluated. That entry retires at the next edge, never the same one.
- Full: `in_ready`=0. There is no same-cycle pass-through while full, even if the head retires.
- `busy_mask` is combinational from the valid entries and includes entries retiring this cycle.
- Pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- Reset (async, any time): all entries are invalidated and pending loads are discarded. Output values on reset:
  - `regWrite`=1, `rd`=0, `writeData`=0
  - `count`=0, `busy_mask`=0, `resp_err`=0
  - `in_ready`=1 once `reset` is high

## Timing
- Non-load accepted at edge E0, empty queue, no bypass: it is head during E0–E1 and retires at E1. `regWrite`=0 during E1–E2 and the bank writes at E2.
- Load accepted at E0, response sampled at Er ≥ E1 (entry is head): retire at Er+1, with `regWrite`=0 during Er+1–Er+2.
- Throughput is one retire per cycle when the head entries are ready.
- A stalled head (load without data) blocks all younger entries.

## Configuration
- `WB_BYPASS_EN` defined:
  - A non-load accepted at E0 while `count`=0 and no entry is retiring skips storage.
  - `rd`/`writeData` are registered at E0 and `regWrite`=0 during E0–E1, so latency is one cycle shorter.
  - `count` and `busy_mask` are never updated for a bypassed entry.
- Undefined: every entry goes through the queue, with latency as in Timing.

## Test plan
- Reset mid-operation: 3 entries queued (one load pending), pull `reset` low → `count`=0, `regWrite`=1, `busy_mask`=0 immediately; a later `load_resp_valid` sets `resp_err`=1.
- Back-to-back non-loads to x5=0x11, x6=0x22, x7=0x33 → `regWrite`=0 on three consecutive cycles with rd 5,6,7 and matching data; `busy_mask` bits clear in order.
- Load to x10 followed by non-load to x11=0xAA, response 0xDEADBEEF after 4 cycles → x10 is written first with 0xDEADBEEF, then x11; `busy_mask[11]` stays set until its retire.
- Fill to DEPTH with a stalled head load → `in_ready`=0, `count`=DEPTH; the response frees one slot per cycle and no entry is lost or duplicated.
- Entry with rd=0, data 0x55 → dequeues, `regWrite` stays 1, `busy_mask`=0.
- `WB_BYPASS_EN` defined, empty queue, non-load x3=0x7 at E0 → `regWrite`=0 during E0–E1; without the macro, during E1–E2.
